mips_regfile: RTL



---
 rtl/mips_regfile_pkg.sv | 20 ++
 rtl/mips_regfile_read_port.sv | 39 +++
 rtl/mips_regfile.sv | 83 ++++++++
 3 files changed

// File: rtl/mips_regfile_pkg.sv
// Shared definitions for the MIPS register file, regdst mux and decoder:
// default widths, the register-address type and well-known register numbers.
package mips_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

    localparam int WRITE_COUNT_W = 16;

    // True when the address selects the hardwired-zero register.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/mips_regfile_read_port.sv
// One combinational read port: forces $0 to zero and optionally forwards
// the value being written this cycle to a matching read address.
module regfile_read_port
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic [DATA_W-1:0] read_data
);

    localparam bit USE_BYPASS = (BYPASS != 0);

    logic addr_is_zero;
    logic forward;

    assign addr_is_zero = (read_addr == ADDR_W'(REG_ZERO));
    assign forward      = USE_BYPASS && write_en && (write_addr == read_addr);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        read_data = '0;
        if (!addr_is_zero) begin
            if (forward) begin
                read_data = write_data;
            end else begin
                read_data = stored_data;
            end
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: two async read ports with optional
// write bypass, one synchronous write port, a debug port and a write counter.
module mips_regfile
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        read_addr_1,
    input  logic [ADDR_W-1:0]        read_addr_2,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        read_data_1,
    output logic [DATA_W-1:0]        read_data_2,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [WRITE_COUNT_W-1:0] write_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [WRITE_COUNT_W-1:0] COUNT_MAX = '1;

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [WRITE_COUNT_W-1:0] count;
    logic                     commit;

    // Writes to $0 are dropped so the entry stays zero and is not counted.
    assign commit = RegWrite && (write_addr != ADDR_W'(REG_ZERO));

    // NOTE: the array is cleared on reset because software may read any
    // register before writing it and must see zero; this keeps it in flops.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (commit) begin
            regs[write_addr] <= write_data;
            if (count != COUNT_MAX) begin
                count <= count + 1'b1;
            end
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_1 (
        .read_addr   (read_addr_1),
        .stored_data (regs[read_addr_1]),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_en    (RegWrite),
        .read_data   (read_data_1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_2 (
        .read_addr   (read_addr_2),
        .stored_data (regs[read_addr_2]),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_en    (RegWrite),
        .read_data   (read_data_2)
    );

    // Debug reads never forward, so they always show committed state.
    assign dbg_data = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : regs[dbg_addr];

    assign write_count = count;

endmodule
